// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and its issue sequencer:
//   - ALU function select encodings
//   - alu_issue FSM state type
//   - default multicycle divide latency
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DIV_LATENCY_DEF = 64;

    localparam logic [2:0] ALU_SEL_ADDSUB = 3'b000;
    localparam logic [2:0] ALU_SEL_MUL    = 3'b001;
    localparam logic [2:0] ALU_SEL_DIV    = 3'b010;
    localparam logic [2:0] ALU_SEL_SLL    = 3'b011;
    localparam logic [2:0] ALU_SEL_SRL    = 3'b100;
    localparam logic [2:0] ALU_SEL_XOR    = 3'b101;
    localparam logic [2:0] ALU_SEL_OR     = 3'b110;
    localparam logic [2:0] ALU_SEL_AND    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } alu_issue_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Request/response bundle between issue/decode (master side drives the
// request and consumes the response) and alu_issue (slave side).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds valid and its payload stable until that edge;
// ready may depend combinationally on the other side's signals.
//   req_*  : request channel   (master -> slave payload, slave -> master ready)
//   rsp_*  : response channel  (slave -> master payload, master -> slave ready)
// ---------------------------------------------------------------------------
interface alu_issue_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_in1;
    logic [63:0] req_in2;
    logic [1:0]  req_control;
    logic [2:0]  req_select;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_out;
    logic        rsp_zero;
    logic        rsp_neg;
    logic        rsp_negu;

    modport master (
        output req_valid, req_in1, req_in2, req_control, req_select, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_zero, rsp_neg, rsp_negu
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_control, req_select, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_zero, rsp_neg, rsp_negu
    );

endinterface

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Initiator-side sequencer for the execute-stage alu. Accepts one operation
// per request handshake, holds the alu operands stable while the alu works,
// counts out the divide latency, then captures the result into a held
// response until the consumer takes it.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : abort current operation, drop pending response
//   bus          : request/response channel (alu_issue_if.slave)
//   alu_in1/2    : registered operands to the alu
//   alu_control  : registered ALUOp control
//   alu_select   : registered function select
//   alu_out      : alu result
//   alu_zero/neg/negu : alu flags
//   busy         : high while in EXEC
//   dbg_state    : current FSM state
// ---------------------------------------------------------------------------
module alu_issue
    import alu_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int CNT_W       = $clog2(DIV_LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_issue_if.slave       bus,
    output logic [63:0]      alu_in1,
    output logic [63:0]      alu_in2,
    output logic [1:0]       alu_control,
    output logic [2:0]       alu_select,
    input  logic [63:0]      alu_out,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_negu,
    output logic             busy,
    output alu_issue_state_t dbg_state
);

    alu_issue_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_alu_in1;
    logic [63:0]      r_alu_in2;
    logic [1:0]       r_alu_control;
    logic [2:0]       r_alu_select;
    logic             r_rsp_valid;
    logic [63:0]      r_rsp_out;
    logic             r_rsp_zero;
    logic             r_rsp_neg;
    logic             r_rsp_negu;

    logic             w_req_ready;
    logic             w_accept;

    // A new operation may start from HOLD only when the held response is
    // leaving in the same cycle, so the response register is never overrun.
    assign w_req_ready = !flush && ((r_state == IDLE) ||
                                    ((r_state == HOLD) && bus.rsp_ready));
    assign w_accept    = bus.req_valid && w_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_alu_in1     <= '0;
            r_alu_in2     <= '0;
            r_alu_control <= '0;
            r_alu_select  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_out     <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_neg     <= 1'b0;
            r_rsp_negu    <= 1'b0;
        end else if (flush) begin
            // Operand and response data registers deliberately keep their
            // last values; only the control state is abandoned.
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rsp_out   <= alu_out;
                        r_rsp_zero  <= alu_zero;
                        r_rsp_neg   <= alu_neg;
                        r_rsp_negu  <= alu_negu;
                        r_rsp_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // An accept (only possible from IDLE or a draining HOLD) takes
            // precedence over the state update above.
            if (w_accept) begin
                r_alu_in1     <= bus.req_in1;
                r_alu_in2     <= bus.req_in2;
                r_alu_control <= bus.req_control;
                r_alu_select  <= bus.req_select;
                r_cnt         <= (bus.req_select == ALU_SEL_DIV) ?
                                 CNT_W'(DIV_LATENCY - 1) : '0;
                r_state       <= EXEC;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_out   = r_rsp_out;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_neg   = r_rsp_neg;
    assign bus.rsp_negu  = r_rsp_negu;

    assign alu_in1     = r_alu_in1;
    assign alu_in2     = r_alu_in2;
    assign alu_control = r_alu_control;
    assign alu_select  = r_alu_select;

    assign busy      = (r_state == EXEC);
    assign dbg_state = r_state;

endmodule
